sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/sweep_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sweep_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer
//   Walks a X_CELLS x Y_CELLS cell grid once per accepted game_tick. Each
//   cell spends SETTLE_CYCLES cycles settling, then one WRITE cycle that
//   pulses write_flag for the current (writeLoc_x, writeLoc_y). After the
//   last cell a one-cycle DONE state pulses frame_done.
//
//   Optional feature: define SWEEP_OVERRUN_CNT_EN to count ticks that are
//   dropped because a sweep is in progress. The counter saturates at 255.
//   Without the macro, overrun_cnt is tied to 0.
//
// Ports
//   Clk          single clock, rising edge
//   Reset_n      asynchronous active-low reset
//   RUN          sweeping permitted while high; low mid-frame aborts it
//   KEY_PAUSE    raw active-low pause button (asynchronous, synchronised here)
//   game_tick    one-cycle request for a full-grid update
//   writeLoc_x   current cell column
//   writeLoc_y   current cell row
//   write_flag   commit strobe for the current cell
//   hold_locs    coordinates frozen (IDLE/DONE)
//   sweep_busy   frame in progress (SETTLE/WRITE)
//   frame_done   one-cycle pulse after the last cell commits
//   overrun_cnt  saturating count of ticks lost to a busy sweep
module sweep_sequencer #(
  parameter int X_bits        = 8,
  parameter int Y_bits        = 7,
  parameter int X_CELLS       = 160,
  parameter int Y_CELLS       = 120,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RUN,
  input  logic              KEY_PAUSE,
  input  logic              game_tick,
  output logic [X_bits-1:0] writeLoc_x,
  output logic [Y_bits-1:0] writeLoc_y,
  output logic              write_flag,
  output logic              hold_locs,
  output logic              sweep_busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WRITE,
    DONE
  } state_t;

  localparam logic [X_bits-1:0] X_LAST      = X_bits'(X_CELLS - 1);
  localparam logic [Y_bits-1:0] Y_LAST      = Y_bits'(Y_CELLS - 1);
  localparam logic [X_bits-1:0] X_ONE       = X_bits'(1);
  localparam logic [Y_bits-1:0] Y_ONE       = Y_bits'(1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [X_bits-1:0] x_d;
  logic [Y_bits-1:0] y_d;
  logic              pause_s1, pause_s2;
  logic              paused;

  assign paused = ~pause_s2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = writeLoc_x;
    y_d     = writeLoc_y;
    unique case (state_q)
      IDLE: begin
        x_d   = '0;
        y_d   = '0;
        cnt_d = '0;
        if (game_tick && RUN && !paused) state_d = SETTLE;
      end
      SETTLE: begin
        if (!RUN) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE: begin
        if (!RUN) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (writeLoc_x == X_LAST && writeLoc_y == Y_LAST) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          cnt_d   = '0;
          if (writeLoc_x == X_LAST) begin
            x_d = '0;
            y_d = writeLoc_y + Y_ONE;
          end else begin
            x_d = writeLoc_x + X_ONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and stay glitch-free.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      writeLoc_x <= '0;
      writeLoc_y <= '0;
      write_flag <= 1'b0;
      hold_locs  <= 1'b1;
      sweep_busy <= 1'b0;
      frame_done <= 1'b0;
      pause_s1   <= 1'b1;
      pause_s2   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      writeLoc_x <= x_d;
      writeLoc_y <= y_d;
      write_flag <= (state_d == WRITE);
      hold_locs  <= (state_d == IDLE) || (state_d == DONE);
      sweep_busy <= (state_d == SETTLE) || (state_d == WRITE);
      frame_done <= (state_d == DONE);
      pause_s1   <= KEY_PAUSE;
      pause_s2   <= pause_s1;
    end
  end

`ifdef SWEEP_OVERRUN_CNT_EN
  // A tick is only an overrun if it would have been accepted in IDLE.
  logic tick_drop;
  assign tick_drop = game_tick && RUN && !paused && (state_q != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overrun_cnt <= '0;
    end else if (tick_drop && overrun_cnt != 8'hFF) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sweep_sequencer.sv
module tb_sweep_sequencer;

  localparam int XC = 4;
  localparam int YC = 3;
  localparam int SC = 2;
  localparam int FRAME = XC * YC * (SC + 1) + 1;

  logic       Clk;
  logic       Reset_n;
  logic       RUN;
  logic       KEY_PAUSE;
  logic       game_tick;
  logic [7:0] writeLoc_x;
  logic [6:0] writeLoc_y;
  logic       write_flag;
  logic       hold_locs;
  logic       sweep_busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  int passed = 0;
  int total  = 0;
  int model_ovr = 0;

  int wr_x[$];
  int wr_y[$];
  int wr_t[$];
  int done_t;

  sweep_sequencer #(
    .X_bits(8),
    .Y_bits(7),
    .X_CELLS(XC),
    .Y_CELLS(YC),
    .SETTLE_CYCLES(SC)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .RUN(RUN),
    .KEY_PAUSE(KEY_PAUSE),
    .game_tick(game_tick),
    .writeLoc_x(writeLoc_x),
    .writeLoc_y(writeLoc_y),
    .write_flag(write_flag),
    .hold_locs(hold_locs),
    .sweep_busy(sweep_busy),
    .frame_done(frame_done),
    .overrun_cnt(overrun_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the k-th committed cell in raster order, and the cycle
  // (relative to the first SETTLE cycle) in which its write strobe appears.
  function automatic int exp_x(input int k);
    return k % XC;
  endfunction
  function automatic int exp_y(input int k);
    return k / XC;
  endfunction
  function automatic int exp_t(input int k);
    return k * (SC + 1) + SC;
  endfunction
  function automatic int exp_ovr();
`ifdef SWEEP_OVERRUN_CNT_EN
    return (model_ovr > 255) ? 255 : model_ovr;
`else
    return 0;
`endif
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_frame();
    game_tick = 1'b1;
    cyc();
    game_tick = 1'b0;
  endtask

  // Observes a frame from its first SETTLE cycle. Optionally injects a tick in
  // the WRITE of cell tick_write_k, a tick in DONE, and a 3-cycle pause window
  // starting at pause_at with a tick on the window's last cycle.
  task automatic capture_frame(input int tick_write_k, input bit tick_done,
                               input int pause_at, input int bound);
    wr_x.delete();
    wr_y.delete();
    wr_t.delete();
    done_t = -1;
    for (int i = 0; i < bound; i++) begin
      game_tick = 1'b0;
      KEY_PAUSE = !(pause_at >= 0 && i >= pause_at && i < pause_at + 3);
      if (pause_at >= 0 && i == pause_at + 2) game_tick = 1'b1;
      if (write_flag) begin
        if (wr_x.size() == tick_write_k) game_tick = 1'b1;
        wr_x.push_back(int'(writeLoc_x));
        wr_y.push_back(int'(writeLoc_y));
        wr_t.push_back(i);
      end
      if (frame_done) begin
        if (tick_done) game_tick = 1'b1;
        done_t = i;
        cyc();
        break;
      end
      cyc();
    end
    game_tick = 1'b0;
    KEY_PAUSE = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    RUN = 1'b1;
    KEY_PAUSE = 1'b1;
    game_tick = 1'b0;
    #12;
    total++;
    if ({writeLoc_x, writeLoc_y, write_flag, hold_locs, sweep_busy, frame_done, overrun_cnt}
        !== {8'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_state: x=%0d y=%0d wf=%b hold=%b busy=%b done=%b ovr=%0d, need 0 0 0 1 0 0 0",
               writeLoc_x, writeLoc_y, write_flag, hold_locs, sweep_busy, frame_done, overrun_cnt);
    end else passed++;
    Reset_n = 1'b1;
    model_ovr = 0;
    cyc();
    cyc();
  endtask

  task automatic test_single_frame();
    int gap;
    gap = $urandom_range(0, 5);
    repeat (gap) cyc();
    start_frame();
    total++;
    if ({sweep_busy, hold_locs, writeLoc_x, writeLoc_y} !== {1'b1, 1'b0, 8'd0, 7'd0}) begin
      $display("FAIL frame_start: busy=%b hold=%b x=%0d y=%0d, need 1 0 0 0",
               sweep_busy, hold_locs, writeLoc_x, writeLoc_y);
    end else passed++;
    capture_frame(-1, 1'b0, -1, 200);
    total++;
    if (wr_x.size() !== XC * YC) begin
      $display("FAIL frame_write_count: got %0d, need %0d", wr_x.size(), XC * YC);
    end else passed++;
    for (int k = 0; k < wr_x.size() && k < XC * YC; k++) begin
      total++;
      if (wr_x[k] !== exp_x(k) || wr_y[k] !== exp_y(k) || wr_t[k] !== exp_t(k)) begin
        $display("FAIL frame_cell_%0d: got (%0d,%0d)@%0d, need (%0d,%0d)@%0d",
                 k, wr_x[k], wr_y[k], wr_t[k], exp_x(k), exp_y(k), exp_t(k));
      end else passed++;
    end
    total++;
    if (done_t + 1 !== FRAME) begin
      $display("FAIL frame_length: got %0d cycles, need %0d", done_t + 1, FRAME);
    end else passed++;
    total++;
    if ({hold_locs, sweep_busy, frame_done, writeLoc_x, writeLoc_y} !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0}) begin
      $display("FAIL frame_idle_after: hold=%b busy=%b done=%b x=%0d y=%0d, need 1 0 0 0 0",
               hold_locs, sweep_busy, frame_done, writeLoc_x, writeLoc_y);
    end else passed++;
  endtask

  task automatic test_drop_overrun();
    int busy_seen;
    start_frame();
    capture_frame(4, 1'b1, -1, 200);
    model_ovr += 2;
    total++;
    if (wr_x.size() !== XC * YC || done_t + 1 !== FRAME) begin
      $display("FAIL drop_frame_intact: writes=%0d len=%0d, need %0d %0d",
               wr_x.size(), done_t + 1, XC * YC, FRAME);
    end else passed++;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (!hold_locs || write_flag) busy_seen++;
      cyc();
    end
    total++;
    if (busy_seen !== 0) begin
      $display("FAIL drop_not_queued: busy cycles after frame=%0d, need 0", busy_seen);
    end else passed++;
    total++;
    if (int'(overrun_cnt) !== exp_ovr()) begin
      $display("FAIL drop_overrun_cnt: got %0d, need %0d", overrun_cnt, exp_ovr());
    end else passed++;
  endtask

  task automatic test_pause();
    int pause_at;
    int busy_seen;
    pause_at = $urandom_range(3, 20);
    start_frame();
    capture_frame(-1, 1'b0, pause_at, 200);
    total++;
    if (wr_x.size() !== XC * YC || done_t + 1 !== FRAME) begin
      $display("FAIL pause_frame_completes: writes=%0d len=%0d, need %0d %0d",
               wr_x.size(), done_t + 1, XC * YC, FRAME);
    end else passed++;
    total++;
    if (int'(overrun_cnt) !== exp_ovr()) begin
      $display("FAIL pause_overrun_unchanged: got %0d, need %0d", overrun_cnt, exp_ovr());
    end else passed++;
    // Tick in IDLE while paused must not start a frame.
    KEY_PAUSE = 1'b0;
    cyc();
    cyc();
    game_tick = 1'b1;
    cyc();
    game_tick = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (!hold_locs || write_flag) busy_seen++;
      cyc();
    end
    total++;
    if (busy_seen !== 0) begin
      $display("FAIL pause_idle_tick_ignored: busy cycles=%0d, need 0", busy_seen);
    end else passed++;
    KEY_PAUSE = 1'b1;
    repeat (3) cyc();
    // Tick with RUN low must not start a frame either.
    RUN = 1'b0;
    game_tick = 1'b1;
    cyc();
    game_tick = 1'b0;
    total++;
    if ({hold_locs, sweep_busy} !== 2'b10) begin
      $display("FAIL run_low_tick_ignored: hold=%b busy=%b, need 1 0", hold_locs, sweep_busy);
    end else passed++;
    RUN = 1'b1;
    cyc();
    total++;
    if (int'(overrun_cnt) !== exp_ovr()) begin
      $display("FAIL ignored_ticks_not_overrun: got %0d, need %0d", overrun_cnt, exp_ovr());
    end else passed++;
  endtask

  task automatic test_run_abort();
    int n;
    int r;
    int late;
    start_frame();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (write_flag) n++;
      if (n == 6) break;
      cyc();
    end
    cyc();
    total++;
    if ({writeLoc_x, writeLoc_y, write_flag, hold_locs} !== {8'(exp_x(6)), 7'(exp_y(6)), 1'b0, 1'b0}) begin
      $display("FAIL abort_cell6_settle: x=%0d y=%0d wf=%b hold=%b, need %0d %0d 0 0",
               writeLoc_x, writeLoc_y, write_flag, hold_locs, exp_x(6), exp_y(6));
    end else passed++;
    r = $urandom_range(0, SC - 1);
    repeat (r) cyc();
    RUN = 1'b0;
    cyc();
    total++;
    if ({hold_locs, sweep_busy, write_flag, frame_done, writeLoc_x, writeLoc_y}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0}) begin
      $display("FAIL abort_to_idle: hold=%b busy=%b wf=%b done=%b x=%0d y=%0d, need 1 0 0 0 0 0",
               hold_locs, sweep_busy, write_flag, frame_done, writeLoc_x, writeLoc_y);
    end else passed++;
    RUN = 1'b1;
    late = 0;
    for (int i = 0; i < 10; i++) begin
      if (write_flag || frame_done) late++;
      cyc();
    end
    total++;
    if (late !== 0) begin
      $display("FAIL abort_no_more_strobes: got %0d, need 0", late);
    end else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    start_frame();
    n = 0;
    while (!write_flag && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (write_flag !== 1'b1) begin
      $display("FAIL areset_reach_write: write_flag=%b after %0d cycles, need 1", write_flag, n);
    end else passed++;
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({write_flag, hold_locs, sweep_busy, overrun_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      $display("FAIL areset_immediate: wf=%b hold=%b busy=%b ovr=%0d, need 0 1 0 0",
               write_flag, hold_locs, sweep_busy, overrun_cnt);
    end else passed++;
    model_ovr = 0;
    #2 Reset_n = 1'b1;
    cyc();
    cyc();
    start_frame();
    capture_frame(-1, 1'b0, -1, 200);
    total++;
    if (wr_x.size() !== XC * YC || wr_x[0] !== 0 || wr_y[0] !== 0 || wr_t[0] !== exp_t(0)) begin
      $display("FAIL areset_restart_origin: writes=%0d first=(%0d,%0d)@%0d, need %0d (0,0)@%0d",
               wr_x.size(), (wr_x.size() > 0) ? wr_x[0] : -1, (wr_y.size() > 0) ? wr_y[0] : -1,
               (wr_t.size() > 0) ? wr_t[0] : -1, XC * YC, exp_t(0));
    end else passed++;
  endtask

  task automatic test_saturate();
    int rem;
    int drops;
    int bad;
    bit t;
    Reset_n = 1'b0;
    #1;
    Reset_n = 1'b1;
    cyc();
    model_ovr = 0;
    rem = 0;
    drops = 0;
    bad = 0;
    for (int c = 0; c < 20000 && drops < 300; c++) begin
      t = ($urandom_range(0, 3) != 0);
      game_tick = t;
      if (rem > 0) begin
        if (t) drops++;
        rem--;
      end else if (t) begin
        rem = FRAME;
      end
      cyc();
      if (sweep_busy !== (rem > 1) || frame_done !== (rem == 1)) bad++;
    end
    game_tick = 1'b0;
    model_ovr = drops;
    total++;
    if (drops < 300) begin
      $display("FAIL sat_drop_budget: dropped %0d ticks, need 300", drops);
    end else passed++;
    total++;
    if (bad !== 0) begin
      $display("FAIL sat_busy_timeline: %0d cycles disagree with model, need 0", bad);
    end else passed++;
    total++;
    if (int'(overrun_cnt) !== exp_ovr()) begin
      $display("FAIL sat_overrun_cnt: got %0d, need %0d", overrun_cnt, exp_ovr());
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_drop_overrun();
    test_pause();
    test_run_abort();
    test_async_reset();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
